alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU controller, together with the two operands.
- Single-cycle ops (logic, add/sub, compare) return a registered result one cycle after acceptance.
- Shifts run iteratively, SHIFT_STEP bits per cycle, to save area.
- Valid/ready handshake on both sides so the pipeline control can stall or flush it.

Parameters:
- WIDTH, 32, operand/result width; power of 2, ≥8.
- SHIFT_STEP, 1, max bits shifted per cycle in SHIFT state; power of 2, 1..WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept; high only in IDLE.
- operation  input  4  ALU op code (encoding below).
- src_a  input  WIDTH  operand A (rs1 / PC).
- src_b  input  WIDTH  operand B (rs2 / imm); shift amount = src_b[$clog2(WIDTH)-1:0].
- flush  input  1  synchronous abort of any in-flight op.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).
- illegal_op  output  1  registered; op code undefined.
- busy  output  1  state != IDLE.

Behaviour:
- Operation encoding:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SUB
  - 0101 SRL
  - 0110 SLL
  - 0111 SRA
  - 1000 EQ: result = {0…, a==b}
  - 1101 SLT (signed): result = {0…, $signed(a)<$signed(b)}
  - All others: result 0, illegal_op=1.
- Arithmetic: ADD/SUB modulo 2^WIDTH, no carry/overflow output.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Accept on in_valid && in_ready, latching operation, src_a and shamt.
  - Non-shift op: result, zero, illegal_op registered at the accept edge; next state DONE. out_valid is high the cycle after accept, so latency is 1.
  - Shift op with shamt==0: result=src_a; next state DONE, latency 1.
  - Shift op with shamt>0: working register=src_a, remaining=shamt; next state SHIFT.
- SHIFT:
  - Each cycle, shift the working register by k=min(SHIFT_STEP, remaining) and decrement remaining by k.
  - SRA fills with the original sign bit; SRL/SLL fill with 0.
  - When remaining becomes 0, load result/zero and go to DONE.
  - Latency from accept to out_valid = 1 + ceil(shamt/SHIFT_STEP).
- DONE: out_valid=1.
  - result, zero and illegal_op are held stable until out_valid && out_ready, then go to IDLE.
  - in_ready=0 in DONE; there is no overlap of requests.
- Backpressure: out_ready low holds DONE indefinitely; outputs do not change.
- flush: in any state, next state is IDLE, out_valid=0 on the next cycle, and the in-flight op is discarded.
  - flush has priority over acceptance and completion.
  - A request presented with flush in IDLE is not accepted.
- Reset, asserted at any time, including mid-shift: state=IDLE, out_valid=0, result=0, zero=0, illegal_op=0, busy=0; remaining and the working register are cleared.
  - Release is synchronous-safe: the first accept can happen on the first edge after rst_n rises.
- Inputs are sampled only at the accept edge; operand changes afterwards have no effect.

Optional Feature:
- Macro: ALU_SEQ_FAST_SHIFT_EN.
- Defined: shifts use a single-cycle barrel shifter and never enter SHIFT. All ops have latency 1; SHIFT_STEP is ignored.
- Undefined: iterative shifting as described above.
- Handshake, reset and flush behaviour are identical in both builds.

Test Plan:
- ADD: rst_n released, in_valid with op 0010, a=5, b=7, out_ready=1 → out_valid exactly 1 cycle later, result=12, zero=0; back in IDLE the next cycle.
- SUB/SLT/EQ:
  - op 0100, a=3, b=5 → 0xFFFFFFFE.
  - op 1101, a=0xFFFFFFFF, b=1 → 1.
  - op 1000, a=b=0x1234 → 1; op 0100, a=b → 0 with zero=1.
- Iterative SRA: SHIFT_STEP=1, op 0111, a=0x80000000, b=31 → out_valid 32 cycles after accept, result=0xFFFFFFFF.
  - SHIFT_STEP=4, SLL, a=1, b=9 → 1+3=4 cycles, result=0x200.
  - SRL with b=0 → 1 cycle, result=a.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid → result stable and in_ready=0 throughout; completes on the first out_ready=1 cycle.
- Flush/reset mid-op:
  - flush during the 10th SHIFT cycle → IDLE next cycle, out_valid never asserts.
  - rst_n low mid-shift → outputs 0 immediately, before the next edge.
  - A following ADD of 1+1 returns 2.
- Illegal op: op 1010 → result 0, illegal_op=1 for one transaction; the next legal op clears it.
  - With ALU_SEQ_FAST_SHIFT_EN defined, SRA by 31 has latency 1.

Source files
------------

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle for the execute-stage ALU.
// The master side issues operations and consumes results; the slave side is the ALU.
interface alu_seq_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal_op;
    logic             busy;

    modport master (
        output in_valid, operation, src_a, src_b, flush, out_ready,
        input  in_ready, out_valid, result, zero, illegal_op, busy
    );

    modport slave (
        input  in_valid, operation, src_a, src_b, flush, out_ready,
        output in_ready, out_valid, result, zero, illegal_op, busy
    );
endinterface

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare, iterative shifts of SHIFT_STEP bits/cycle.
// Define ALU_SEQ_FAST_SHIFT_EN to replace the iterative shifter with a one-cycle barrel shifter.
module alu_seq_exec #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_seq_exec_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SRL = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_EQ  = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b1101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   rem_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             illegal_q;
    logic             out_valid_q;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    assign shamt = bus.src_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.operation)
            OP_AND: alu_res = bus.src_a & bus.src_b;
            OP_OR:  alu_res = bus.src_a | bus.src_b;
            OP_ADD: alu_res = bus.src_a + bus.src_b;
            OP_XOR: alu_res = bus.src_a ^ bus.src_b;
            OP_SUB: alu_res = bus.src_a - bus.src_b;
            OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, bus.src_a == bus.src_b};
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
`ifdef ALU_SEQ_FAST_SHIFT_EN
            OP_SRL: alu_res = bus.src_a >> shamt;
            OP_SLL: alu_res = bus.src_a << shamt;
            OP_SRA: alu_res = $signed(bus.src_a) >>> shamt;
`else
            // Only reached with shamt==0 at accept; nonzero amounts go through SHIFT.
            OP_SRL, OP_SLL, OP_SRA: alu_res = bus.src_a;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifndef ALU_SEQ_FAST_SHIFT_EN
    localparam logic [SHW:0] STEP_W = (SHW+1)'(SHIFT_STEP);

    logic             is_shift;
    logic [SHW:0]     step_k;
    logic [WIDTH-1:0] work_step;
    logic [SHW-1:0]   rem_step;

    assign is_shift = (bus.operation == OP_SRL) || (bus.operation == OP_SLL) ||
                      (bus.operation == OP_SRA);

    // The arithmetic shift keeps the MSB, so the original sign bit propagates each step.
    always_comb begin
        step_k    = ({1'b0, rem_q} < STEP_W) ? {1'b0, rem_q} : STEP_W;
        rem_step  = rem_q - step_k[SHW-1:0];
        work_step = work_q;
        case (op_q)
            OP_SRL:  work_step = work_q >> step_k;
            OP_SLL:  work_step = work_q << step_k;
            OP_SRA:  work_step = $signed(work_q) >>> step_k;
            default: work_step = work_q;
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        op_q <= bus.operation;
`ifdef ALU_SEQ_FAST_SHIFT_EN
                        begin
`else
                        if (is_shift && (shamt != '0)) begin
                            work_q  <= bus.src_a;
                            rem_q   <= shamt;
                            state_q <= SHIFT;
                        end else begin
`endif
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                            illegal_q   <= alu_ill;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
`ifndef ALU_SEQ_FAST_SHIFT_EN
                SHIFT: begin
                    work_q <= work_step;
                    rem_q  <= rem_step;
                    if (rem_step == '0) begin
                        result_q    <= work_step;
                        zero_q      <= (work_step == '0);
                        illegal_q   <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.illegal_op = illegal_q;
endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases plus random ops against a reference model.
module tb_alu_seq_exec;
    localparam int W    = 32;
    localparam int STEP = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_seq_exec_if #(.WIDTH(W)) bus ();

    alu_seq_exec #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int sh;
        sh = int'(b % W);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a - b;
            4'd5:    return a >> sh;
            4'd6:    return a << sh;
            4'd7:    return $signed(a) >>> sh;
            4'd8:    return (a == b) ? 1 : 0;
            4'd13:   return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_ill(input logic [3:0] op);
        return !(op <= 4'd8 || op == 4'd13);
    endfunction

    function automatic int ref_lat(input logic [3:0] op, input logic [W-1:0] b);
        int sh;
        sh = int'(b % W);
        if (op < 4'd5 || op > 4'd7) return 1;
`ifdef ALU_SEQ_FAST_SHIFT_EN
        return 1;
`else
        if (sh == 0) return 1;
        return 1 + (sh + STEP - 1) / STEP;
`endif
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_r;
        logic [W-1:0] held;
        int           exp_lat;
        int           n;
        exp_r   = ref_res(op, a, b);
        exp_lat = ref_lat(op, b);
        chk({tag, " in_ready_pre"}, bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.operation = 4'($urandom);
        bus.src_a     = $urandom;
        bus.src_b     = $urandom;
        n = 1;
        @(negedge clk);
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        $display("op=%b a=%h b=%h result=%h zero=%b illegal=%b latency=%0d", op, a, b,
                 bus.result, bus.zero, bus.illegal_op, n);
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " result"}, bus.result, exp_r);
        chk({tag, " zero"}, bus.zero, (exp_r == '0));
        chk({tag, " illegal"}, bus.illegal_op, ref_ill(op));
        chk({tag, " in_ready_done"}, bus.in_ready, 0);
        chk({tag, " busy_done"}, bus.busy, 1);
        if (hold > 0) begin
            held = bus.result;
            repeat (hold) begin
                @(negedge clk);
                chk({tag, " hold_result"}, bus.result, held);
                chk({tag, " hold_valid"}, bus.out_valid, 1);
                chk({tag, " hold_in_ready"}, bus.in_ready, 0);
            end
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, " out_valid_post"}, bus.out_valid, 0);
        chk({tag, " in_ready_post"}, bus.in_ready, 1);
    endtask

    initial begin
        int          seen;
        logic [3:0]  rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        checks = 0;
        errors = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.operation = 4'd0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst result", bus.result, 0);
        chk("rst zero", bus.zero, 0);
        chk("rst illegal", bus.illegal_op, 0);
        chk("rst busy", bus.busy, 0);
        rst_n = 1'b1;

        do_op("add", 4'b0010, 32'd5, 32'd7, 0);
        do_op("sub_neg", 4'b0100, 32'd3, 32'd5, 0);
        do_op("slt", 4'b1101, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("eq", 4'b1000, 32'h1234, 32'h1234, 0);
        do_op("sub_zero", 4'b0100, 32'h1234, 32'h1234, 0);
        do_op("sra31", 4'b0111, 32'h8000_0000, 32'd31, 0);
        do_op("sll9", 4'b0110, 32'd1, 32'd9, 0);
        do_op("srl0", 4'b0101, 32'hDEAD_BEEF, 32'd0, 0);
        do_op("backpressure", 4'b0011, 32'hF0F0_1234, 32'h0FF0_4321, 3);
        do_op("illegal", 4'b1010, 32'h55, 32'h66, 0);
        do_op("after_illegal", 4'b0001, 32'h0F00, 32'h00F0, 0);

        // Flush while the long shift is still in flight.
        bus.in_valid  = 1'b1;
        bus.operation = 4'b0111;
        bus.src_a     = 32'h8000_0000;
        bus.src_b     = 32'd31;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush out_valid", bus.out_valid, 0);
        chk("flush busy", bus.busy, 0);
        chk("flush in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("flush no_valid", seen, 0);

        // A request presented together with flush must be ignored.
        bus.in_valid  = 1'b1;
        bus.flush     = 1'b1;
        bus.operation = 4'b0010;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        chk("flush_req busy", bus.busy, 0);
        chk("flush_req out_valid", bus.out_valid, 0);

        // Reset mid-shift: outputs clear before the next clock edge.
        do_op("pre_reset", 4'b0110, 32'd1, 32'd9, 0);
        bus.in_valid  = 1'b1;
        bus.operation = 4'b0111;
        bus.src_a     = 32'h8000_0000;
        bus.src_b     = 32'd31;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid result", bus.result, 0);
        chk("rst_mid out_valid", bus.out_valid, 0);
        chk("rst_mid busy", bus.busy, 0);
        chk("rst_mid zero", bus.zero, 0);
        chk("rst_mid illegal", bus.illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("add_after_rst", 4'b0010, 32'd1, 32'd1, 0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, W - 1)) : $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            do_op("rand", rop, ra, rb, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
